vic_nested: RTL and testbench
=============================

# vic_nested

Parametrised nested vectored interrupt controller, the successor to the fixed 31-line VIC. It takes N_IRQ external request lines, each with its own enable, trigger mode and priority. It redirects the CPU to a per-channel vector whenever a pending request outranks the running level, and saves PC and condition codes on an internal stack so higher-priority interrupts can preempt lower ones. It sits between the external interrupt pins and the CPU fetch stage, in the same position as the current VIC control path.

## Interface
- N_IRQ, 31, number of interrupt channels (1..64)
- PRIO_W, 2, priority width; 2^PRIO_W priority values, 0 lowest
- ISR_BASE, 32'h0000_0100, vector of channel 0; channel k vector = ISR_BASE + 4*k
- SEL_W, $clog2(N_IRQ) (minimum 1), channel-select width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_PC  in  32  PC of the instruction to resume at
- i_CCodes  in  4  current CPU condition codes
- i_reti  in  1  one-cycle pulse: return-from-interrupt executed
- i_ext  in  N_IRQ  raw interrupt request lines
- i_gen  in  1  global interrupt enable
- i_cfg_we  in  1  configuration write strobe
- i_cfg_sel  in  SEL_W  channel to read/write
- i_cfg_data  in  PRIO_W+3  {en, mode[1:0], prio}
- o_cfg_data  out  PRIO_W+3  combinational readback of channel i_cfg_sel
- o_VIC_ctrl  out  1  one-cycle redirect pulse to CPU
- o_VIC_iaddr  out  32  redirect target, valid while o_VIC_ctrl=1
- o_CCodes  out  4  restored condition codes, valid from the cycle o_VIC_ctrl=1 on a return; held otherwise
- o_pending  out  N_IRQ  pending bits
- o_level  out  PRIO_W+1  running level: 0 = thread, p+1 = servicing priority p

## Operation
- Mode encoding: 00 level-high, 01 rising edge, 10 falling edge, 11 both edges.
- Edge detection compares i_ext with a registered copy ext_q, which resets to 0. A line that is high when reset is released therefore produces a rising edge.
- Pending set:
  - Edge modes: pending is set on the qualifying edge and held until the channel is accepted.
  - Level mode: pending is set every cycle the line is high. After acceptance it re-sets next cycle if the line is still high.
- Disabled channels (en=0) never set pending. A config write with en=0 clears that channel's pending bit the same cycle.
- Arbitration selects the highest prio among pending channels. Ties go to the lowest index.
- Acceptance happens in cycle t when all of the following hold:
  - i_gen=1
  - state = IDLE
  - i_reti=0
  - a candidate exists with prio+1 > o_level
- On acceptance:
  - Push {i_PC, i_CCodes, o_level} onto the stack.
  - Clear the winner's pending bit.
  - Set o_level = prio+1.
  - Enter state ENTER.
- ENTER (1 cycle): o_VIC_ctrl=1, o_VIC_iaddr = ISR_BASE + 4*idx. Then go to IDLE.
- On i_reti=1 in IDLE with a non-empty stack:
  - Pop the stack.
  - Enter state RETURN, with o_VIC_iaddr = saved PC, o_CCodes = saved CC, o_level = saved level.
- RETURN (1 cycle): o_VIC_ctrl=1. Then go to IDLE.
- Stack depth is 2^PRIO_W. Each push strictly raises the level, so overflow cannot occur.
- i_reti with an empty stack is ignored: no pulse, no state change.
- Pending bits keep accumulating in every state, including while i_gen=0.

## Timing
- Reset values:
  - o_VIC_ctrl=0, o_VIC_iaddr=0, o_CCodes=0, o_level=0, o_pending=0
  - all config = 0 (every channel disabled)
  - stack empty, state IDLE
- Edge to pending: an edge on i_ext in cycle t sets pending at the t+1 clock edge. Pending is visible in cycle t+1.
- Pending to redirect: a pending bit visible in cycle t gives o_VIC_ctrl=1 in cycle t+1.
- Return latency: i_reti in cycle t gives the return pulse in cycle t+1.
- No new acceptance can occur during ENTER or RETURN. The earliest following acceptance is evaluated in the cycle after the pulse.
- Simultaneous i_reti and eligible request: the return wins. The request stays pending and is re-arbitrated against the restored level.
- A config write takes effect on the next edge and affects arbitration from the next cycle.
- Reset asserted mid-operation (any state) immediately forces all reset values and empties the stack.

## Test plan
- Basic entry: ch3 enabled, rising, prio 1; pulse i_ext[3] with i_PC=0x40 and CC=4'hA -> one cycle later pending[3]=1; next cycle o_VIC_ctrl=1, o_VIC_iaddr=0x10C, o_level=2.
- Return: then pulse i_reti with CC=4'h0 -> next cycle o_VIC_ctrl=1, o_VIC_iaddr=0x40, o_CCodes=4'hA, o_level=0.
- Preemption/nesting: ch3 running at prio 1; raise ch7 (prio 3) -> redirect to 0x11C, level 4. Raise ch5 (prio 1) -> no redirect while level 4 or 2. Two i_reti -> return to ch3's PC, then thread; ch5 then taken once level is 0.
- Tie-break: ch2 and ch9 both prio 2 and pending in the same cycle -> ch2 vector 0x108 first; ch9 is taken after ch2 returns.
- Level mode/disable: ch0 level mode held high -> re-pends after return and re-enters. Write en=0 -> pending[0]=0 next cycle and no further entries. i_gen=0 blocks all entries while pending bits stay set.
- Reset and stray reti: assert rst during ENTER -> all outputs 0 and stack empty. i_reti with empty stack -> no o_VIC_ctrl pulse.

Source files
------------

// File: rtl/vic_nested.sv
// vic_nested: nested vectored interrupt controller with per-channel enable/mode/priority and a PC/CC/level stack.
module vic_nested #(
  parameter int          N_IRQ    = 31,
  parameter int          PRIO_W   = 2,
  parameter logic [31:0] ISR_BASE = 32'h0000_0100,
  parameter int          SEL_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         i_PC,
  input  logic [3:0]          i_CCodes,
  input  logic                i_reti,
  input  logic [N_IRQ-1:0]    i_ext,
  input  logic                i_gen,
  input  logic                i_cfg_we,
  input  logic [SEL_W-1:0]    i_cfg_sel,
  input  logic [PRIO_W+2:0]   i_cfg_data,
  output logic [PRIO_W+2:0]   o_cfg_data,
  output logic                o_VIC_ctrl,
  output logic [31:0]         o_VIC_iaddr,
  output logic [3:0]          o_CCodes,
  output logic [N_IRQ-1:0]    o_pending,
  output logic [PRIO_W:0]     o_level
);
  localparam int CW = PRIO_W + 3;
  localparam int LW = PRIO_W + 1;
  localparam int D  = 2 ** PRIO_W;
  typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]     r_cfg [N_IRQ];
  logic [N_IRQ-1:0]  r_ext_q, r_pend, w_set, w_clr;
  logic [31:0]       r_stk_pc [D];
  logic [3:0]        r_stk_cc [D];
  logic [LW-1:0]     r_stk_lv [D];
  logic [LW-1:0]     r_sp, r_level, w_lv_new;
  logic [31:0]       r_iaddr;
  logic [3:0]        r_cc;
  logic              w_found, w_accept, w_ret, w_sel_ok;
  logic [SEL_W-1:0]  w_idx;
  logic [PRIO_W-1:0] w_prio, w_top;
  assign w_sel_ok    = 32'(i_cfg_sel) < N_IRQ;
  assign o_cfg_data  = w_sel_ok ? r_cfg[i_cfg_sel] : '0;
  assign o_VIC_ctrl  = r_state != IDLE;
  assign o_VIC_iaddr = r_iaddr;
  assign o_CCodes    = r_cc;
  assign o_pending   = r_pend;
  assign o_level     = r_level;
  assign w_top       = PRIO_W'(r_sp - LW'(1));
  // mode bit 0 selects rising edges, bit 1 falling edges; 00 is level-high
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_prio  = '0;
    w_set   = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      w_set[k] = r_cfg[k][CW-1] & ((r_cfg[k][CW-2:PRIO_W] == 2'b00) ? i_ext[k] :
                 (r_cfg[k][PRIO_W] & i_ext[k] & ~r_ext_q[k]) | (r_cfg[k][PRIO_W+1] & ~i_ext[k] & r_ext_q[k]));
      if (r_pend[k] && (!w_found || r_cfg[k][PRIO_W-1:0] > w_prio)) begin
        w_found = 1'b1;
        w_idx   = SEL_W'(k);
        w_prio  = r_cfg[k][PRIO_W-1:0];
      end
    end
    w_lv_new = LW'(w_prio) + LW'(1);
    w_accept = i_gen && r_state == IDLE && !i_reti && w_found && w_lv_new > r_level;
    w_ret    = r_state == IDLE && i_reti && r_sp != '0;
    w_clr    = (w_accept ? N_IRQ'(1) << w_idx : '0) |
               ((i_cfg_we && w_sel_ok && !i_cfg_data[CW-1]) ? N_IRQ'(1) << i_cfg_sel : '0);
    w_next   = w_accept ? ENTER : w_ret ? RETURN : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ext_q <= '0;
      r_pend  <= '0;
      r_sp    <= '0;
      r_level <= '0;
      r_iaddr <= '0;
      r_cc    <= '0;
      for (int k = 0; k < N_IRQ; k++) r_cfg[k] <= '0;
    end else begin
      r_state <= w_next;
      r_ext_q <= i_ext;
      r_pend  <= (r_pend | w_set) & ~w_clr;
      if (i_cfg_we && w_sel_ok) r_cfg[i_cfg_sel] <= i_cfg_data;
      if (w_accept) begin
        r_sp    <= r_sp + LW'(1);
        r_level <= w_lv_new;
        r_iaddr <= ISR_BASE + (32'(w_idx) << 2);
      end else if (w_ret) begin
        r_sp    <= r_sp - LW'(1);
        r_level <= r_stk_lv[w_top];
        r_iaddr <= r_stk_pc[w_top];
        r_cc    <= r_stk_cc[w_top];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_stk_pc[r_sp[PRIO_W-1:0]] <= i_PC;
      r_stk_cc[r_sp[PRIO_W-1:0]] <= i_CCodes;
      r_stk_lv[r_sp[PRIO_W-1:0]] <= r_level;
    end
  end
endmodule

// File: tb/tb_vic_nested.sv
// tb_vic_nested: directed checks of entry, return, nesting, tie-break, level mode, gating and reset.
module tb_vic_nested;
  logic        clk = 1'b0;
  logic        rst, i_reti, i_gen, i_cfg_we;
  logic [31:0] i_PC;
  logic [3:0]  i_CCodes;
  logic [30:0] i_ext;
  logic [4:0]  i_cfg_sel;
  logic [4:0]  i_cfg_data, o_cfg_data;
  logic        o_VIC_ctrl;
  logic [31:0] o_VIC_iaddr;
  logic [3:0]  o_CCodes;
  logic [30:0] o_pending;
  logic [2:0]  o_level;
  int checks = 0, failures = 0;

  vic_nested dut (
    .clk(clk), .rst(rst), .i_PC(i_PC), .i_CCodes(i_CCodes), .i_reti(i_reti),
    .i_ext(i_ext), .i_gen(i_gen), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel),
    .i_cfg_data(i_cfg_data), .o_cfg_data(o_cfg_data), .o_VIC_ctrl(o_VIC_ctrl),
    .o_VIC_iaddr(o_VIC_iaddr), .o_CCodes(o_CCodes), .o_pending(o_pending), .o_level(o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [4:0] d);
    i_cfg_we = 1'b1; i_cfg_sel = 5'(ch); i_cfg_data = d;
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic pulse(input int ch);
    i_ext[ch] = 1'b1; tick();
    i_ext[ch] = 1'b0;
  endtask

  task automatic redir(input string tag, input logic [31:0] a, input logic [2:0] lv);
    chk({tag, "_ctrl"}, o_VIC_ctrl, 1);
    chk({tag, "_iaddr"}, o_VIC_iaddr, a);
    chk({tag, "_level"}, o_level, lv);
  endtask

  initial begin
    rst = 1'b1; i_reti = 0; i_gen = 1; i_cfg_we = 0; i_PC = 0; i_CCodes = 0;
    i_ext = '0; i_cfg_sel = 5'd3; i_cfg_data = 0;
    tick(); tick();
    chk("rst_ctrl", o_VIC_ctrl, 0);
    chk("rst_iaddr", o_VIC_iaddr, 0);
    chk("rst_cc", o_CCodes, 0);
    chk("rst_level", o_level, 0);
    chk("rst_pend", o_pending, 0);
    chk("rst_cfg", o_cfg_data, 0);
    rst = 1'b0; tick();

    // basic entry and return
    wr(3, 5'b10101);
    chk("cfg_rb3", o_cfg_data, 5'b10101);
    i_PC = 32'h40; i_CCodes = 4'hA;
    pulse(3);
    chk("b_pend", o_pending[3], 1);
    chk("b_nopulse", o_VIC_ctrl, 0);
    tick();
    redir("b_enter", 32'h10C, 2);
    chk("b_pclr", o_pending[3], 0);
    tick();
    chk("b_idle", o_VIC_ctrl, 0);
    i_CCodes = 4'h0; i_reti = 1; tick(); i_reti = 0;
    redir("b_ret", 32'h40, 0);
    chk("b_ret_cc", o_CCodes, 4'hA);
    tick();
    chk("b_ret_end", o_VIC_ctrl, 0);
    chk("b_cc_held", o_CCodes, 4'hA);

    // nesting
    wr(7, 5'b10111);
    wr(5, 5'b10101);
    i_PC = 32'h100; i_CCodes = 4'h1;
    pulse(3); tick();
    redir("n_e3", 32'h10C, 2);
    tick();
    i_PC = 32'h200; i_CCodes = 4'h2;
    pulse(7); tick();
    redir("n_e7", 32'h11C, 4);
    tick();
    pulse(5);
    chk("n_p5", o_pending[5], 1);
    tick();
    chk("n_blk4", o_VIC_ctrl, 0);
    i_reti = 1; tick(); i_reti = 0;
    redir("n_r7", 32'h200, 2);
    chk("n_r7_cc", o_CCodes, 4'h2);
    tick();
    chk("n_r7_end", o_VIC_ctrl, 0);
    tick();
    chk("n_blk2", o_VIC_ctrl, 0);
    chk("n_p5_held", o_pending[5], 1);
    i_reti = 1; tick(); i_reti = 0;
    redir("n_r3", 32'h100, 0);
    chk("n_r3_cc", o_CCodes, 4'h1);
    tick();
    chk("n_r3_end", o_VIC_ctrl, 0);
    tick();
    redir("n_e5", 32'h114, 2);
    tick();
    i_reti = 1; tick(); i_reti = 0;
    redir("n_r5", 32'h200, 0);
    tick();
    i_reti = 1; tick(); i_reti = 0;
    chk("stray_reti", o_VIC_ctrl, 0);
    chk("stray_level", o_level, 0);

    // tie-break
    wr(2, 5'b10110);
    wr(9, 5'b10110);
    i_ext[2] = 1; i_ext[9] = 1; tick(); i_ext = '0;
    chk("t_pend", {o_pending[9], o_pending[2]}, 2'b11);
    tick();
    redir("t_e2", 32'h108, 3);
    chk("t_p9", o_pending[9], 1);
    tick();
    chk("t_blk", o_VIC_ctrl, 0);
    i_reti = 1; tick(); i_reti = 0;
    redir("t_r2", 32'h200, 0);
    tick();
    tick();
    redir("t_e9", 32'h124, 3);
    tick();
    i_reti = 1; tick(); i_reti = 0;
    tick();

    // level mode and disable
    wr(0, 5'b10000);
    i_ext[0] = 1; tick();
    chk("l_pend", o_pending[0], 1);
    tick();
    redir("l_e1", 32'h100, 1);
    chk("l_pclr", o_pending[0], 0);
    tick();
    chk("l_repend", o_pending[0], 1);
    chk("l_blk", o_VIC_ctrl, 0);
    i_reti = 1; tick(); i_reti = 0;
    redir("l_r1", 32'h200, 0);
    tick();
    tick();
    redir("l_e2", 32'h100, 1);
    tick();
    i_reti = 1; tick(); i_reti = 0;
    wr(0, 5'b00000);
    chk("l_dis_pend", o_pending[0], 0);
    tick();
    chk("l_dis_ctrl", o_VIC_ctrl, 0);
    chk("l_dis_pend2", o_pending[0], 0);
    i_ext[0] = 0;

    // global enable gating
    i_gen = 0;
    pulse(3); tick(); tick();
    chk("g_blk", o_VIC_ctrl, 0);
    chk("g_pend", o_pending[3], 1);
    i_gen = 1; tick();
    redir("g_e3", 32'h10C, 2);

    // async reset during ENTER, then stray reti on the emptied stack
    rst = 1; #1;
    chk("ar_ctrl", o_VIC_ctrl, 0);
    chk("ar_iaddr", o_VIC_iaddr, 0);
    chk("ar_level", o_level, 0);
    chk("ar_pend", o_pending, 0);
    chk("ar_cfg", o_cfg_data, 0);
    #2 rst = 0;
    tick();
    i_reti = 1; tick(); i_reti = 0;
    chk("ar_reti", o_VIC_ctrl, 0);
    chk("ar_cc", o_CCodes, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
